// File: rtl/adc_scan_ctrl.sv
// Purpose : round-robin scan sequencer for an ADC0808/0809-class converter (mux address, ALE/START/OE, EOC wait, capture).
// Latency : eoc seen 2 cycles late (synchroniser); sample_valid strobes 1 cycle after the last OE cycle.
// Backpr. : none downstream; sample_valid is a one-cycle strobe and sample_data/sample_ch hold until the next capture.
//
// Ports:
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   enable, mode          run while high; 0 = single pass over ch_mask, 1 = continuous
//   ch_mask               per-channel include bits, sampled at channel decisions only
//   eoc, adc_data         converter end-of-conversion (async) and result bus
//   channel_sel, ale,     converter mux address, address latch enable,
//   start, oe             start conversion, output enable
//   sample_data/_ch/_valid captured result, its channel, one-cycle strobe
//   timeout_err           one-cycle strobe when an EOC wait exceeds EOC_TMO cycles
//   busy                  high whenever the sequencer is not idle
module adc_scan_ctrl #(
   parameter int DATA_W  = 8,
   parameter int NUM_CH  = 8,
   parameter int CH_W    = 3,
   parameter int START_W = 2,
   parameter int OE_WAIT = 2,
   parameter int EOC_TMO = 1024
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic              mode,
   input  logic [NUM_CH-1:0] ch_mask,
   input  logic              eoc,
   input  logic [DATA_W-1:0] adc_data,
   output logic [CH_W-1:0]   channel_sel,
   output logic              ale,
   output logic              start,
   output logic              oe,
   output logic [DATA_W-1:0] sample_data,
   output logic [CH_W-1:0]   sample_ch,
   output logic              sample_valid,
   output logic              timeout_err,
   output logic              busy
);

   localparam int CNT_MAX = (START_W > OE_WAIT) ? START_W : OE_WAIT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int TMO_W   = $clog2(EOC_TMO + 1);

   typedef enum logic [2:0] {IDLE, SETUP, PULSE, WAIT_LO, WAIT_HI, READ} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [TMO_W-1:0] tmo_cnt;
   logic             eoc_m;
   logic             eoc_s;

   // Channel index base+k modulo NUM_CH (k in 0..NUM_CH).
   function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base, input int k);
      int idx;
      idx = int'(base) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      return CH_W'(idx);
   endfunction

   // first_ch: first enabled channel at/after the current one (used when leaving IDLE).
   // next_ch : first enabled channel strictly after the current one; k == NUM_CH lands
   //           back on the current channel, so a single-channel mask repeats and counts
   //           as a completed pass.
   logic [CH_W-1:0] first_ch;
   logic [CH_W-1:0] next_ch;
   logic            next_wrap;
   logic            go_on;

   always_comb begin
      first_ch  = channel_sel;
      next_ch   = channel_sel;
      next_wrap = 1'b1;
      // Descending loops so the smallest distance wins.
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (ch_mask[wrap_add(channel_sel, k)]) first_ch = wrap_add(channel_sel, k);
      end
      for (int k = NUM_CH; k >= 1; k--) begin
         if (ch_mask[wrap_add(channel_sel, k)]) begin
            next_ch   = wrap_add(channel_sel, k);
            next_wrap = (int'(channel_sel) + k) >= NUM_CH;
         end
      end
   end

   // Continue scanning after a conversion, or fall back to IDLE.
   assign go_on = enable && (|ch_mask) && (mode || !next_wrap);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         eoc_m <= 1'b0;
         eoc_s <= 1'b0;
      end else begin
         eoc_m <= eoc;
         eoc_s <= eoc_m;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         channel_sel  <= '0;
         ale          <= 1'b0;
         start        <= 1'b0;
         oe           <= 1'b0;
         sample_data  <= '0;
         sample_ch    <= '0;
         sample_valid <= 1'b0;
         timeout_err  <= 1'b0;
         busy         <= 1'b0;
         cnt          <= '0;
         tmo_cnt      <= '0;
      end else begin
         sample_valid <= 1'b0;
         timeout_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (enable && (|ch_mask)) begin
                  channel_sel <= first_ch;
                  busy        <= 1'b1;
                  state       <= SETUP;
               end
            end
            SETUP: begin
               // Address has been stable for one cycle; raise ALE and START together.
               ale   <= 1'b1;
               start <= 1'b1;
               cnt   <= '0;
               state <= PULSE;
            end
            PULSE: begin
               if (cnt == CNT_W'(START_W - 1)) begin
                  ale     <= 1'b0;
                  start   <= 1'b0;
                  tmo_cnt <= '0;
                  state   <= WAIT_LO;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WAIT_LO: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               // Timeout wins over a late EOC edge in the same cycle.
               if (tmo_cnt == TMO_W'(EOC_TMO - 1)) begin
                  timeout_err <= 1'b1;
                  busy        <= go_on;
                  if (go_on) begin
                     channel_sel <= next_ch;
                     state       <= SETUP;
                  end else begin
                     state <= IDLE;
                  end
               end else if (!eoc_s) begin
                  state <= WAIT_HI;
               end
            end
            WAIT_HI: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               if (tmo_cnt == TMO_W'(EOC_TMO - 1)) begin
                  timeout_err <= 1'b1;
                  busy        <= go_on;
                  if (go_on) begin
                     channel_sel <= next_ch;
                     state       <= SETUP;
                  end else begin
                     state <= IDLE;
                  end
               end else if (eoc_s) begin
                  oe    <= 1'b1;
                  cnt   <= '0;
                  state <= READ;
               end
            end
            READ: begin
               if (cnt == CNT_W'(OE_WAIT - 1)) begin
                  // Bus has had OE_WAIT cycles to settle; capture on the last OE cycle.
                  oe           <= 1'b0;
                  sample_data  <= adc_data;
                  sample_ch    <= channel_sel;
                  sample_valid <= 1'b1;
                  busy         <= go_on;
                  if (go_on) begin
                     channel_sel <= next_ch;
                     state       <= SETUP;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Purpose : directed bench for adc_scan_ctrl with an ADC0809-like converter model and a sample scoreboard.
// Latency : converter drops eoc 2 cycles after START rises, raises it 20 cycles later.
// Backpr. : none; every sample_valid pops one expected (channel, data) entry.
module tb_adc_scan_ctrl;

   localparam int DW  = 8;
   localparam int NCH = 8;
   localparam int CW  = 3;
   localparam int SW  = 3;
   localparam int OW  = 2;
   localparam int TMO = 64;

   logic           clk = 1'b0;
   logic           reset_n;
   logic           enable = 1'b0;
   logic           mode = 1'b0;
   logic [NCH-1:0] ch_mask = '0;
   logic           eoc = 1'b1;
   logic [DW-1:0]  adc_data;
   logic [CW-1:0]  channel_sel;
   logic           ale, start, oe;
   logic [DW-1:0]  sample_data;
   logic [CW-1:0]  sample_ch;
   logic           sample_valid, timeout_err, busy;

   always #5 clk = ~clk;

   adc_scan_ctrl #(
      .DATA_W(DW), .NUM_CH(NCH), .CH_W(CW), .START_W(SW), .OE_WAIT(OW), .EOC_TMO(TMO)
   ) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .ch_mask(ch_mask),
      .eoc(eoc), .adc_data(adc_data), .channel_sel(channel_sel), .ale(ale), .start(start),
      .oe(oe), .sample_data(sample_data), .sample_ch(sample_ch), .sample_valid(sample_valid),
      .timeout_err(timeout_err), .busy(busy)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [CW-1:0] ch;
      logic [DW-1:0] dat;
   } exp_t;
   exp_t sb[$];

   logic [DW-1:0] tab [NCH];
   logic [CW-1:0] lat_ch = '0;
   bit            eoc_stuck = 1'b0;

   // Converter model: result per channel, driven only while OE is high.
   assign adc_data = oe ? tab[lat_ch] : 'x;

   initial begin
      forever begin
         @(posedge start);
         lat_ch = channel_sel;
         repeat (2) @(posedge clk);
         #1 eoc = 1'b0;
         if (!eoc_stuck) begin
            repeat (20) @(posedge clk);
            #1 eoc = 1'b1;
         end
      end
   end

   // Protocol monitor and scoreboard consumer.
   int valid_cnt = 0, start_rises = 0, tmo_seen = 0;
   int start_len = 0, oe_len = 0, since_fall = 0, tmo_gap = 0;
   logic [CW-1:0] tmo_ch = '0;
   logic [CW-1:0] prev_ch = '0;
   logic prev_start = 1'b0, prev_oe = 1'b0, prev_valid = 1'b0, prev_ale = 1'b0;

   always @(negedge clk) begin
      if (reset_n !== 1'b1) begin
         start_len = 0; oe_len = 0; since_fall = 0;
         prev_start = 1'b0; prev_oe = 1'b0; prev_valid = 1'b0; prev_ale = 1'b0;
      end else begin
         checks++;
         assert (!(oe && (start || ale)) && (start === ale))
         else begin
            errors++;
            $error("FAIL overlap: oe=%b start=%b ale=%b required oe exclusive and start==ale", oe, start, ale);
         end
         if (ale && prev_ale) begin
            checks++;
            assert (channel_sel === prev_ch)
            else begin errors++; $error("FAIL chsel_during_ale: got %0d required %0d", channel_sel, prev_ch); end
         end
         if (start && !prev_start) start_rises++;
         if (start) start_len++;
         else if (prev_start) begin
            checks++;
            assert (start_len == SW)
            else begin errors++; $error("FAIL start_width: got %0d required %0d", start_len, SW); end
            start_len = 0;
         end
         if (oe) oe_len++;
         else if (prev_oe) begin
            checks++;
            assert (oe_len == OW)
            else begin errors++; $error("FAIL oe_width: got %0d required %0d", oe_len, OW); end
            oe_len = 0;
         end
         if (prev_start && !start) since_fall = 1;
         else if (since_fall > 0) since_fall++;
         if (timeout_err === 1'b1) begin
            tmo_seen++;
            tmo_gap = since_fall - 1;
            tmo_ch  = channel_sel;
         end
         if (sample_valid === 1'b1) begin
            valid_cnt++;
            checks++;
            assert (!prev_valid && sb.size() > 0)
            else begin errors++; $error("FAIL unexpected_valid: got ch=%0d queue=%0d required one-cycle expected sample", sample_ch, sb.size()); end
            if (sb.size() > 0) begin
               exp_t e;
               e = sb.pop_front();
               checks++;
               assert (sample_ch === e.ch && sample_data === e.dat)
               else begin
                  errors++;
                  $error("FAIL sample: got ch=%0d dat=%h required ch=%0d dat=%h", sample_ch, sample_data, e.ch, e.dat);
               end
            end
         end
         prev_start = start; prev_oe = oe; prev_valid = sample_valid; prev_ale = ale; prev_ch = channel_sel;
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      assert (act === exp)
      else begin errors++; $error("FAIL %s: got %0h required %0h", tag, act, exp); end
   endtask

   task automatic push(input logic [CW-1:0] ch);
      exp_t e;
      e.ch  = ch;
      e.dat = tab[ch];
      sb.push_back(e);
   endtask

   task automatic wait_valids(input int target, input string tag);
      int n = 0;
      while (valid_cnt < target && n < 3000) begin @(negedge clk); #1; n++; end
      check(tag, 32'(valid_cnt >= target), 1);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy !== 1'b0 && n < 3000) begin @(negedge clk); #1; n++; end
      check(tag, 32'(busy), 0);
   endtask

   task automatic do_reset();
      enable  = 1'b0;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk); #1;
   endtask

   initial begin
      int base, n, rises;
      logic busy_first, busy_last;
      for (int i = 0; i < NCH; i++) tab[i] = 8'(8'h11 * (i + 1));
      tab[2] = 8'h5C;

      // Reset state
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_outputs", {24'd0, channel_sel, ale, start, oe, sample_valid, timeout_err},
            32'd0);
      check("reset_sample", {21'd0, busy, sample_ch, sample_data}, 32'd0);
      reset_n = 1'b1;
      @(negedge clk); #1;

      // Test 1: continuous scan over 8'hA5
      ch_mask = 8'hA5; mode = 1'b1;
      push(0); push(2); push(5); push(7); push(0); push(2);
      enable = 1'b1;
      wait_valids(6, "scan_a5_six");
      push(5);
      enable = 1'b0;
      wait_valids(7, "scan_a5_finish");
      wait_idle("scan_a5_idle");
      check("scan_a5_sb_empty", sb.size(), 0);

      // Test 2: single pass over 8'h18
      do_reset();
      ch_mask = 8'h18; mode = 1'b0;
      push(3); push(4);
      base = valid_cnt; busy_first = 1'bx; busy_last = 1'bx; n = 0;
      enable = 1'b1;
      while (valid_cnt < base + 2 && n < 3000) begin
         @(negedge clk); #1; n++;
         if (sample_valid && valid_cnt == base + 1) busy_first = busy;
         if (sample_valid && valid_cnt == base + 2) busy_last = busy;
      end
      enable = 1'b0;
      check("pass_busy_mid", 32'(busy_first), 1);
      check("pass_busy_end", 32'(busy_last), 0);
      repeat (100) @(negedge clk);
      #1;
      check("pass_two_samples", valid_cnt - base, 2);

      // Test 3: EOC never returns high -> timeout, next channel
      do_reset();
      eoc_stuck = 1'b1;
      ch_mask = 8'h06; mode = 1'b1;
      base = valid_cnt; n = 0;
      enable = 1'b1;
      while (tmo_seen < 1 && n < 500) begin @(negedge clk); #1; n++; end
      check("tmo_seen", 32'(tmo_seen), 1);
      check("tmo_gap", 32'(tmo_gap), TMO);
      check("tmo_next_ch", 32'(tmo_ch), 2);
      check("tmo_sample_hold", {24'd0, sample_data}, 0);
      enable = 1'b0;
      wait_idle("tmo_idle");
      check("tmo_no_sample", valid_cnt - base, 0);
      eoc_stuck = 1'b0;
      eoc = 1'b1;
      repeat (5) @(negedge clk);

      // Test 4: drop enable while waiting for EOC high
      do_reset();
      ch_mask = 8'hFF; mode = 1'b1;
      push(0);
      base = valid_cnt; n = 0;
      enable = 1'b1;
      while (eoc !== 1'b0 && n < 200) begin @(negedge clk); #1; n++; end
      repeat (4) @(negedge clk);
      enable = 1'b0;
      wait_valids(base + 1, "drop_en_sample");
      wait_idle("drop_en_idle");
      rises = start_rises;
      repeat (100) @(negedge clk);
      #1;
      check("drop_en_no_start", 32'(start_rises - rises), 0);
      check("drop_en_one_sample", valid_cnt - base, 1);

      // Test 5: reset during READ, restart from ch0
      do_reset();
      ch_mask = 8'hA5; mode = 1'b1;
      push(0);
      n = 0;
      enable = 1'b1;
      while (oe !== 1'b1 && n < 300) begin @(negedge clk); #1; n++; end
      check("read_reached", 32'(oe), 1);
      void'(sb.pop_front());
      push(0);
      reset_n = 1'b0;
      #1;
      check("reset_in_read", {27'd0, oe, start, ale, sample_valid, busy}, 0);
      repeat (3) @(negedge clk);
      base = valid_cnt;
      reset_n = 1'b1;
      wait_valids(base + 1, "restart_ch0");
      push(2);
      enable = 1'b0;
      wait_valids(base + 2, "restart_ch2");
      wait_idle("restart_idle");
      check("final_sample_5c", {24'd0, sample_data}, 32'h5C);
      check("final_sb_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
